nic_her_scheduler: RTL
======================

NIC_HER_SCHEDULER -- requirements
Module: nic_her_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning the number of HER descriptor sources (2..16).
REQ-002 SHALL have parameter HER_W, default 128, meaning the width of the HER descriptor in bits.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 16, meaning the maximum number of descriptors issued to pspin without feedback; CW = $clog2(MAX_INFLIGHT+1).
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_ni, input, 1, the reset, asynchronous and active-low.
REQ-006 SHALL have port en_i, input, 1, the scheduler enable.
REQ-007 SHALL have port src_valid_i, input, NUM_SRC, per-source descriptor valid.
REQ-008 SHALL have port src_ready_o, output, NUM_SRC, per-source accept (one-hot or zero).
REQ-009 SHALL have port src_her_i, input, NUM_SRC*HER_W, per-source descriptors, with source k at bits [k*HER_W +: HER_W].
REQ-010 SHALL have port src_done_i, input, NUM_SRC, a per-source level meaning no further descriptors.
REQ-011 SHALL have ports her_valid_o (output, 1), her_ready_i (input, 1) and her_o (output, HER_W), the descriptor stream to pspin.
REQ-012 SHALL have ports feedback_valid_i (input, 1) and feedback_ready_o (output, 1), the pspin completion feedback handshake.
REQ-013 SHALL have port eos_o, output, 1, end-of-stream to pspin.
REQ-014 SHALL have port inflight_o, output, CW, the current in-flight count.
REQ-015 SHALL have port issued_cnt_o, output, 32, the total descriptors accepted; it wraps modulo 2^32.
REQ-016 SHALL have port err_o, output, 1, a sticky feedback-underflow flag.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN and EOS.
REQ-018 SHALL transition IDLE->RUN when en_i=1.
REQ-019 SHALL transition RUN->IDLE when en_i=0.
REQ-020 SHALL transition RUN->DRAIN when all src_done_i bits are 1, taking priority over en_i=0.
REQ-021 SHALL transition DRAIN->EOS when inflight=0 and the output register is empty.
REQ-022 SHALL transition EOS->IDLE when en_i=0.
REQ-023 SHALL accept a source descriptor only in RUN, with inflight<MAX_INFLIGHT, and with the output register either empty or completing its handshake in the same cycle; feedback arriving in that cycle does not create credit.
REQ-024 SHALL arbitrate round-robin: grant the first index >=rr_ptr, modulo NUM_SRC, with src_valid_i=1; rr_ptr resets to 0.
REQ-025 SHALL, on acceptance, set rr_ptr to (granted+1) mod NUM_SRC; rr_ptr SHALL be unchanged when nothing is accepted.
REQ-026 SHALL assert src_ready_o[g] combinationally in the acceptance cycle, and only for the granted source.
REQ-027 SHALL register the granted descriptor into her_o with her_valid_o=1 in the next cycle, giving a latency of 1 cycle.
REQ-028 SHALL hold her_o and her_valid_o stable while her_valid_o=1 and her_ready_i=0.
REQ-029 SHALL clear her_valid_o after the her handshake unless a new descriptor is loaded in the same cycle, which gives back-to-back throughput of 1 per cycle.
REQ-030 SHALL increment inflight on acceptance and decrement it on a feedback handshake; simultaneous increment and decrement SHALL leave it unchanged.
REQ-031 SHALL keep feedback_ready_o=1 in every state outside reset.
REQ-032 SHALL, on feedback with inflight=0, leave inflight at 0 and set err_o=1 until reset.
REQ-033 SHALL increment issued_cnt_o by 1 per acceptance.
REQ-034 SHALL assert eos_o=1 exactly while in state EOS.
REQ-035 SHALL, on a RUN->IDLE transition with the output register occupied, still complete that descriptor normally.

Reset
REQ-036 SHALL, while rst_ni=0 (asynchronous), force: state=IDLE, rr_ptr=0, her_valid_o=0, her_o=0, src_ready_o=0, feedback_ready_o=0, eos_o=0, inflight_o=0, issued_cnt_o=0, err_o=0.
REQ-037 SHALL discard the output-register contents when reset is asserted mid-handshake; no descriptor is replayed after reset release.

Verification
REQ-038 SHALL verify round-robin: en_i=1, all 4 sources valid, her_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles and her_valid_o continuously high from the second cycle.
REQ-039 SHALL verify credit limit: MAX_INFLIGHT=16, no feedback, source 2 always valid -> exactly 16 accepts, then src_ready_o=0 and inflight_o=16; one feedback -> exactly one further accept.
REQ-040 SHALL verify backpressure: her_ready_i=0 for 5 cycles with her_valid_o=1 -> her_o stable and no src_ready_o asserted; her_ready_i=1 -> handshake and next load in the same cycle.
REQ-041 SHALL verify EOS: 3 descriptors issued, src_done_i=all ones -> DRAIN, eos_o=0; 3 feedbacks -> eos_o=1 the cycle after inflight_o reaches 0; en_i=0 -> eos_o=0.
REQ-042 SHALL verify underflow and simultaneity: feedback with inflight=0 -> err_o=1 and inflight_o=0; an accept and a feedback in the same cycle at inflight=5 -> inflight_o stays 5.
REQ-043 SHALL verify mid-operation reset: rst_ni=0 while her_valid_o=1 -> her_valid_o=0 immediately (asynchronous) and all counters 0.

Source files
------------

// File: rtl/nic_her_scheduler.sv
// Round-robin scheduler that forwards HER descriptors from NUM_SRC sources to pspin,
// bounded by an in-flight credit limit and closed with an end-of-stream phase.
module nic_her_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int HER_W        = 128,
  parameter int MAX_INFLIGHT = 16,
  localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  output logic [NUM_SRC-1:0]       src_ready_o,
  input  logic [NUM_SRC*HER_W-1:0] src_her_i,
  input  logic [NUM_SRC-1:0]       src_done_i,
  output logic                     her_valid_o,
  input  logic                     her_ready_i,
  output logic [HER_W-1:0]         her_o,
  input  logic                     feedback_valid_i,
  output logic                     feedback_ready_o,
  output logic                     eos_o,
  output logic [CW-1:0]            inflight_o,
  output logic [31:0]              issued_cnt_o,
  output logic                     err_o
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_EOS} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic              her_vld_q, her_vld_d;
  logic [HER_W-1:0]  her_q, her_d;
  logic [CW-1:0]     infl_q, infl_d;
  logic [31:0]       issued_q, issued_d;
  logic              err_q, err_d;
  logic              eos_q, eos_d;
  logic              fb_rdy_q;

  logic              gnt_vld;
  logic [PW-1:0]     gnt_idx;
  logic [PW:0]       cand;
  logic              accept;
  logic              fb_hs;
  logic              fb_dec;
  logic [HER_W-1:0]  her_sel;

  // Scan from rr_q upwards with wrap; the first valid source wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = {1'b0, rr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_SRC)) cand = cand - (PW+1)'(NUM_SRC);
      if (!gnt_vld && src_valid_i[cand[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  // Only credit held at the start of the cycle counts; same-cycle feedback never enables an accept.
  assign accept  = (state_q == S_RUN) && (infl_q < CW'(MAX_INFLIGHT)) &&
                   (!her_vld_q || her_ready_i) && gnt_vld;
  assign fb_hs   = feedback_valid_i && fb_rdy_q;
  assign fb_dec  = fb_hs && (infl_q != '0);
  assign her_sel = src_her_i[gnt_idx*HER_W +: HER_W];

  always_comb begin
    src_ready_o = '0;
    if (accept) src_ready_o = NUM_SRC'(1) << gnt_idx;
  end

  always_comb begin
    her_vld_d = her_vld_q;
    her_d     = her_q;
    rr_d      = rr_q;
    issued_d  = issued_q;
    infl_d    = infl_q;
    err_d     = err_q;
    state_d   = state_q;

    if (accept) begin
      her_vld_d = 1'b1;
      her_d     = her_sel;
      rr_d      = (gnt_idx == PW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
      issued_d  = issued_q + 32'd1;
    end else if (her_ready_i) begin
      her_vld_d = 1'b0;
    end

    if (accept && !fb_dec)      infl_d = infl_q + CW'(1);
    else if (!accept && fb_dec) infl_d = infl_q - CW'(1);

    if (fb_hs && (infl_q == '0)) err_d = 1'b1;

    case (state_q)
      S_IDLE:  if (en_i) state_d = S_RUN;
      S_RUN: begin
        if (&src_done_i) state_d = S_DRAIN;
        else if (!en_i)  state_d = S_IDLE;
      end
      S_DRAIN: if ((infl_q == '0) && !her_vld_q) state_d = S_EOS;
      S_EOS:   if (!en_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    eos_d = (state_d == S_EOS);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      her_vld_q <= 1'b0;
      her_q     <= '0;
      infl_q    <= '0;
      issued_q  <= '0;
      err_q     <= 1'b0;
      eos_q     <= 1'b0;
      fb_rdy_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      her_vld_q <= her_vld_d;
      her_q     <= her_d;
      infl_q    <= infl_d;
      issued_q  <= issued_d;
      err_q     <= err_d;
      eos_q     <= eos_d;
      fb_rdy_q  <= 1'b1;
    end
  end

  assign her_valid_o      = her_vld_q;
  assign her_o            = her_q;
  assign feedback_ready_o = fb_rdy_q;
  assign eos_o            = eos_q;
  assign inflight_o       = infl_q;
  assign issued_cnt_o     = issued_q;
  assign err_o            = err_q;

endmodule
